// File: rtl/clk_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_ctrl_pkg
// Description : Shared command/state encodings and default widths for the
//               divided-clock event counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_ctrl_pkg;

   localparam int DEF_DIV_W = 28;
   localparam int DEF_CNT_W = 8;

   localparam logic [1:0] OP_START      = 2'd0;
   localparam logic [1:0] OP_STOP       = 2'd1;
   localparam logic [1:0] OP_LOAD_LIMIT = 2'd2;
   localparam logic [1:0] OP_CLEAR      = 2'd3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/clk_counter_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_counter_ctrl_if
// Description : Valid/ready command port of the event counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_counter_ctrl_if
   import clk_ctrl_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_data;
   logic [DIV_W-1:0] div_cfg;

   modport master (output cmd_valid, cmd_op, cmd_data, div_cfg, input cmd_ready);
   modport slave  (input cmd_valid, cmd_op, cmd_data, div_cfg, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/clk_counter_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Programmable prescaler; registered one-cycle tick every div+1
//               enabled cycles, restartable from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
   import clk_ctrl_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   localparam logic [DIV_W-1:0] c_one = DIV_W'(1);

   logic [DIV_W-1:0] pre_q, pre_d;
   logic             tick_q, tick_d;

   always_comb begin
      pre_d  = pre_q;
      tick_d = 1'b0;
      if (restart) begin
         pre_d = '0;
      end else if (en) begin
         if (pre_q == div) begin
            pre_d  = '0;
            tick_d = 1'b1;
         end else begin
            pre_d = pre_q + c_one;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;
endmodule
`default_nettype wire

// File: rtl/clk_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_counter_ctrl
// Description : Single-clock event counter advanced by a prescaler tick and
//               sequenced through a valid/ready command port.
//               Optional down-counting mode: define CLK_CTRL_DOWN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_counter_ctrl
   import clk_ctrl_pkg::*;
#(
   parameter int          DIV_W     = DEF_DIV_W,
   parameter int          CNT_W     = DEF_CNT_W,
   parameter int unsigned DIV_RESET = 50000000
) (
   input  logic                 clk,
   input  logic                 rst,
   clk_counter_ctrl_if.slave    cmd,
   output logic                 tick,
   output logic [CNT_W-1:0]     q,
   output logic                 running,
   output logic                 done
);
   localparam logic [DIV_W-1:0] c_div_reset = DIV_W'(DIV_RESET);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] q_q, q_d;
   logic [CNT_W-1:0] limit_q, limit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             wrap_q, wrap_d;
   logic             done_q, done_d;
   logic             restart;
   logic             cmd_fire;
   logic [CNT_W-1:0] term_val, reload_val, step_val;

`ifdef CLK_CTRL_DOWN_EN
   logic down_q, down_d;
   assign term_val   = down_q ? '0 : limit_q;
   assign reload_val = down_q ? limit_q : '0;
   assign step_val   = down_q ? (q_q - c_one) : (q_q + c_one);
`else
   assign term_val   = limit_q;
   assign reload_val = '0;
   assign step_val   = q_q + c_one;
`endif

   // The limit is frozen while counting, so LOAD_LIMIT is back-pressured in RUN.
   assign cmd.cmd_ready = !((state_q == ST_RUN) && (cmd.cmd_op == OP_LOAD_LIMIT));
   assign cmd_fire      = cmd.cmd_valid && cmd.cmd_ready;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      limit_d = limit_q;
      div_d   = div_q;
      wrap_d  = wrap_q;
      done_d  = 1'b0;
      restart = 1'b0;
`ifdef CLK_CTRL_DOWN_EN
      down_d  = down_q;
`endif
      if (cmd_fire) begin
         case (cmd.cmd_op)
            OP_START: begin
               state_d = ST_RUN;
               div_d   = cmd.div_cfg;
               wrap_d  = cmd.cmd_data[0];
               restart = 1'b1;
`ifdef CLK_CTRL_DOWN_EN
               down_d  = cmd.cmd_data[1];
               q_d     = cmd.cmd_data[1] ? limit_q : '0;
`else
               q_d     = '0;
`endif
            end
            OP_STOP: state_d = ST_IDLE;
            OP_LOAD_LIMIT: limit_d = cmd.cmd_data;
            OP_CLEAR: begin
               q_d = reload_val;
               if (state_q == ST_RUN) begin
                  restart = 1'b1;
               end else if (state_q == ST_DONE) begin
                  state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end else if ((state_q == ST_RUN) && tick) begin
         // A tick only counts in a cycle where no command was accepted.
         if (q_q == term_val) begin
            done_d = 1'b1;
            if (wrap_q) begin
               q_d = reload_val;
            end else begin
               state_d = ST_DONE;
            end
         end else begin
            q_d = step_val;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         q_q     <= '0;
         limit_q <= '1;
         div_q   <= c_div_reset;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef CLK_CTRL_DOWN_EN
         down_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         limit_q <= limit_d;
         div_q   <= div_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
`ifdef CLK_CTRL_DOWN_EN
         down_q  <= down_d;
`endif
      end
   end

   tick_gen #(
      .DIV_W (DIV_W)
   ) u_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .en      (state_d == ST_RUN),
      .restart (restart),
      .div     (div_q),
      .tick    (tick)
   );

   assign q       = q_q;
   assign running = (state_q == ST_RUN);
   assign done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_clk_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_counter_ctrl
// Description : Self-checking bench: vector table, corner sequences and
//               randomized commands against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_counter_ctrl;
   import clk_ctrl_pkg::*;

   localparam int          DIV_W     = 28;
   localparam int          CNT_W     = 8;
   localparam int unsigned DIV_RESET = 50000000;
`ifdef CLK_CTRL_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             tick, running, done;
   logic [CNT_W-1:0] q;

   clk_counter_ctrl_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

   clk_counter_ctrl #(
      .DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_RESET(DIV_RESET)
   ) dut (
      .clk(clk), .rst(rst), .cmd(bus), .tick(tick), .q(q), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0=idle 1=run 2=done; ticks fall on multiples of div+1
   // cycles elapsed since the last (re)start.
   int          m_mode;
   int unsigned m_q, m_limit, m_div;
   bit          m_wrap, m_down, m_tick, m_done;
   longint      m_phase;

   function automatic void model_reset();
      m_mode = 0; m_q = 0; m_limit = 255; m_div = DIV_RESET;
      m_wrap = 0; m_down = 0; m_tick = 0; m_done = 0; m_phase = 0;
   endfunction

   function automatic bit model_ready(input bit [1:0] op);
      return !(m_mode == 1 && op == OP_LOAD_LIMIT);
   endfunction

   function automatic void model_step(input bit v, input bit [1:0] op, input bit [7:0] d,
                                      input int unsigned cfg);
      bit fire = v && model_ready(op);
      bit restarted = 0;
      int unsigned term;
      m_done = 0;
      if (fire) begin
         if (op == OP_START) begin
            m_mode = 1; m_div = cfg; m_wrap = d[0]; m_down = DOWN_EN && d[1];
            m_q = m_down ? m_limit : 0; restarted = 1;
         end else if (op == OP_STOP) begin
            m_mode = 0;
         end else if (op == OP_LOAD_LIMIT) begin
            m_limit = d;
         end else begin
            m_q = m_down ? m_limit : 0;
            if (m_mode == 1) restarted = 1;
            else if (m_mode == 2) m_mode = 0;
         end
      end else if (m_mode == 1 && m_tick) begin
         term = m_down ? 0 : m_limit;
         if (m_q == term) begin
            m_done = 1;
            if (m_wrap) m_q = m_down ? m_limit : 0;
            else m_mode = 2;
         end else begin
            m_q = m_down ? m_q - 1 : (m_q + 1) % 256;
         end
      end
      if (restarted) begin
         m_phase = 0; m_tick = 0;
      end else if (m_mode == 1) begin
         m_phase++;
         m_tick = (m_phase % (longint'(m_div) + 1)) == 0;
      end else begin
         m_tick = 0;
      end
   endfunction

   // Called at a negedge: apply inputs, check ready, clock, check outputs vs model.
   task automatic drive_cycle(input bit v, input bit [1:0] op, input bit [7:0] d,
                              input int unsigned cfg, output logic rdy_seen);
      bus.cmd_valid = v; bus.cmd_op = op; bus.cmd_data = d; bus.div_cfg = cfg[DIV_W-1:0];
      #1;
      rdy_seen = bus.cmd_ready;
      check("model_ready", rdy_seen, model_ready(op));
      @(posedge clk);
      model_step(v, op, d, cfg);
      @(negedge clk);
      check("model_q", q, m_q);
      check("model_tick", tick, m_tick);
      check("model_done", done, m_done);
      check("model_running", running, m_mode == 1);
   endtask

   task automatic cmd(input bit [1:0] op, input bit [7:0] d, input int unsigned cfg);
      logic r;
      drive_cycle(1'b1, op, d, cfg, r);
   endtask

   task automatic idle();
      logic r;
      drive_cycle(1'b0, OP_START, 8'd0, 0, r);
   endtask

   typedef struct {
      bit v; bit [1:0] op; bit [7:0] d; int unsigned cfg;
      bit [7:0] eq; bit et; bit ed; bit er; bit ery;
   } vec_t;

   function automatic vec_t mk(input bit v, input bit [1:0] op, input bit [7:0] d,
                               input int unsigned cfg, input bit [7:0] eq, input bit et,
                               input bit ed, input bit er, input bit ery);
      vec_t r;
      r.v = v; r.op = op; r.d = d; r.cfg = cfg;
      r.eq = eq; r.et = et; r.ed = ed; r.er = er; r.ery = ery;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[16];
      logic        rdy;
      bit          found;
      int          ticks, dones, first_tick, last_tick, done_k;
      bit [7:0]    qseq[$];

      tbl[0]  = mk(1, OP_LOAD_LIMIT, 8'd2, 0, 8'd0, 0, 0, 0, 1);
      tbl[1]  = mk(1, OP_START,      8'd1, 0, 8'd0, 0, 0, 1, 1);
      tbl[2]  = mk(0, OP_START,      8'd0, 0, 8'd0, 1, 0, 1, 1);
      tbl[3]  = mk(0, OP_START,      8'd0, 0, 8'd1, 1, 0, 1, 1);
      tbl[4]  = mk(0, OP_START,      8'd0, 0, 8'd2, 1, 0, 1, 1);
      tbl[5]  = mk(0, OP_START,      8'd0, 0, 8'd0, 1, 1, 1, 1);
      tbl[6]  = mk(0, OP_START,      8'd0, 0, 8'd1, 1, 0, 1, 1);
      tbl[7]  = mk(0, OP_START,      8'd0, 0, 8'd2, 1, 0, 1, 1);
      tbl[8]  = mk(0, OP_START,      8'd0, 0, 8'd0, 1, 1, 1, 1);
      tbl[9]  = mk(1, OP_LOAD_LIMIT, 8'd0, 0, 8'd1, 1, 0, 1, 0);
      tbl[10] = mk(0, OP_START,      8'd0, 0, 8'd2, 1, 0, 1, 1);
      tbl[11] = mk(0, OP_START,      8'd0, 0, 8'd0, 1, 1, 1, 1);
      tbl[12] = mk(0, OP_START,      8'd0, 0, 8'd1, 1, 0, 1, 1);
      tbl[13] = mk(1, OP_STOP,       8'd0, 0, 8'd1, 0, 0, 0, 1);
      tbl[14] = mk(1, OP_CLEAR,      8'd0, 0, 8'd0, 0, 0, 0, 1);
      tbl[15] = mk(1, OP_STOP,       8'd0, 0, 8'd0, 0, 0, 0, 1);

      bus.cmd_valid = 0; bus.cmd_op = OP_START; bus.cmd_data = '0; bus.div_cfg = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      repeat (20) idle();
      check("reset_q", q, 0);
      check("reset_tick", tick, 0);
      check("reset_done", done, 0);
      check("reset_running", running, 0);
      check("reset_ready", bus.cmd_ready, 1);

      // Limit 2, div 0, wrap: q 0,1,2,0.. with LOAD_LIMIT refused mid-run.
      for (int i = 0; i < 16; i++) begin
         drive_cycle(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].cfg, rdy);
         check($sformatf("vec%0d_ready", i), rdy, tbl[i].ery);
         check($sformatf("vec%0d_q", i), q, tbl[i].eq);
         check($sformatf("vec%0d_tick", i), tick, tbl[i].et);
         check($sformatf("vec%0d_done", i), done, tbl[i].ed);
         check($sformatf("vec%0d_running", i), running, tbl[i].er);
      end

      // One-shot: limit 5, div 3.
      cmd(OP_LOAD_LIMIT, 8'd5, 0);
      cmd(OP_START, 8'd0, 3);
      ticks = 0; dones = 0; first_tick = -1; last_tick = -1; done_k = -1;
      for (int k = 1; k <= 40; k++) begin
         idle();
         if (tick === 1'b1) begin
            ticks++;
            if (first_tick < 0) first_tick = k;
            last_tick = k;
         end
         if (done === 1'b1) begin
            dones++;
            done_k = k;
         end
      end
      check("oneshot_first_tick", first_tick, 4);
      check("oneshot_last_tick", last_tick, 24);
      check("oneshot_ticks", ticks, 6);
      check("oneshot_dones", dones, 1);
      check("oneshot_done_cycle", done_k, 25);
      check("oneshot_q_hold", q, 5);
      check("oneshot_running", running, 0);

      // CLEAR aligned with a tick (div 1), then STOP at q=3.
      cmd(OP_LOAD_LIMIT, 8'd7, 0);
      check("done_load_running", running, 0);
      cmd(OP_START, 8'd0, 1);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (tick === 1'b1 && q == 8'd2) begin found = 1; break; end
         idle();
      end
      check("wait_tick_q2", found, 1);
      cmd(OP_CLEAR, 8'd0, 0);
      check("clr_tick_q", q, 0);
      check("clr_tick_tick", tick, 0);
      check("clr_tick_running", running, 1);
      idle();
      check("clr_next_q", q, 0);
      check("clr_next_tick", tick, 0);
      idle();
      check("clr_tick2", tick, 1);
      idle();
      check("clr_q1", q, 1);
      found = 0;
      for (int k = 0; k < 30; k++) begin
         if (q == 8'd3) begin found = 1; break; end
         idle();
      end
      check("wait_q3", found, 1);
      cmd(OP_STOP, 8'd0, 0);
      check("stop_q", q, 3);
      check("stop_running", running, 0);
      idle(); idle();
      check("stop_hold_q", q, 3);

      // Asynchronous reset mid-run at q=4.
      cmd(OP_START, 8'd0, 0);
      found = 0;
      for (int k = 0; k < 30; k++) begin
         if (q == 8'd4) begin found = 1; break; end
         idle();
      end
      check("wait_q4", found, 1);
      rst = 1'b1;
      #1;
      check("arst_q", q, 0);
      check("arst_tick", tick, 0);
      check("arst_done", done, 0);
      check("arst_running", running, 0);
      check("arst_ready", bus.cmd_ready, 1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      idle();

`ifdef CLK_CTRL_DOWN_EN
      cmd(OP_LOAD_LIMIT, 8'd3, 0);
      cmd(OP_START, 8'b10, 0);
      check("down_start_q", q, 3);
      found = 0;
      for (int k = 0; k < 20; k++) begin
         idle();
         if (tick === 1'b1) qseq.push_back(q);
         if (done === 1'b1) begin found = 1; break; end
      end
      check("down_done_seen", found, 1);
      check("down_tick_count", qseq.size(), 4);
      for (int i = 0; i < qseq.size() && i < 4; i++)
         check($sformatf("down_seq%0d", i), qseq[i], 3 - i);
      check("down_hold_q", q, 0);
      check("down_running", running, 0);
`endif

      // Randomized commands against the model.
      for (int k = 0; k < 600; k++) begin
         bit          v   = ($urandom % 3) == 0;
         bit [1:0]    op  = 2'($urandom % 4);
         bit [7:0]    d   = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % 6);
         int unsigned cfg = $urandom % 4;
         drive_cycle(v, op, d, cfg, rdy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
